// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scanout
// and a drawing client. During horizontal blanking it prefetches the next
// framebuffer row into a line buffer at top priority. All other RAM cycles
// go to the writer through a req/ack handshake. Pixels are read from the
// line buffer and upscaled by 2^SCALE_LOG2 in both axes.
//
// Ports:
//   clkIn, rstIn                 pixel clock, synchronous active-high reset
//   hPosIn, vPosIn, isDisplayOnIn  position and visible flag from the sync generator
//   pixelOut                     pixel for the position sampled one cycle earlier
//   wrReqIn/wrAddrIn/wrDataIn    writer request, held until wrAckOut
//   wrAckOut                     one-cycle pulse: write performed (or dropped)
//   memAddrOut/memWeOut/memWdataOut  registered RAM command
//   memRdataIn                   RAM read data, one cycle after the address
//   overrunOut                   sticky: trigger seen while a prefetch was running
module vga_fb_arbiter #(
    parameter int unsigned DISPLAY_WIDTH  = 800,
    parameter int unsigned DISPLAY_HEIGHT = 600,
    parameter int unsigned V_TOTAL        = 666,
    parameter int unsigned SCALE_LOG2     = 2,
    parameter int unsigned FB_WIDTH       = 200,
    parameter int unsigned FB_HEIGHT      = 150,
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned DATA_W         = 8
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic [15:0]       hPosIn,
    input  logic [15:0]       vPosIn,
    input  logic              isDisplayOnIn,
    output logic [DATA_W-1:0] pixelOut,
    input  logic              wrReqIn,
    input  logic [ADDR_W-1:0] wrAddrIn,
    input  logic [DATA_W-1:0] wrDataIn,
    output logic              wrAckOut,
    output logic [ADDR_W-1:0] memAddrOut,
    output logic              memWeOut,
    output logic [DATA_W-1:0] memWdataOut,
    input  logic [DATA_W-1:0] memRdataIn,
    output logic              overrunOut
);

    localparam int unsigned COL_W    = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FB_WIDTH + 1);
    localparam int unsigned ROW_W    = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam int unsigned FB_WORDS = FB_WIDTH * FB_HEIGHT;
    localparam logic [15:0] SUB_MASK = 16'((1 << SCALE_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_PREFETCH,
        ST_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wr_ack_q, wr_ack_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   pixel_q, pixel_d;
    // Read pipeline: column on memAddrOut now, and column whose data arrives now.
    logic                rd_vld_q, rd_vld_d;
    logic [COL_W-1:0]    rd_col_q, rd_col_d;
    logic                cap_vld_q, cap_vld_d;
    logic [COL_W-1:0]    cap_col_q, cap_col_d;

    logic [DATA_W-1:0]   line_buf_q [FB_WIDTH];

    logic [15:0]         next_v_c;
    logic                trigger_c;
    logic [ROW_W-1:0]    new_row_c;
    logic [ROW_W-1:0]    row_sel_c;
    logic [ADDR_W-1:0]   first_addr_c;
    logic [ADDR_W-1:0]   next_addr_c;
    logic                wr_in_range_c;
    logic [15:0]         pix_fb_col_c;
    logic [COL_W-1:0]    pix_col_c;

    // Prefetch trigger: start of hblank on the line before a new FB row.
    always_comb begin
        next_v_c     = (vPosIn == 16'(V_TOTAL - 1)) ? 16'd0 : vPosIn + 16'd1;
        trigger_c    = (hPosIn == 16'(DISPLAY_WIDTH))
                    && (next_v_c < 16'(DISPLAY_HEIGHT))
                    && ((next_v_c & SUB_MASK) == 16'd0);
        new_row_c    = ROW_W'(next_v_c >> SCALE_LOG2);
        row_sel_c    = trigger_c ? new_row_c : row_q;
        first_addr_c = ADDR_W'(row_sel_c) * ADDR_W'(FB_WIDTH);
        next_addr_c  = ADDR_W'(row_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(col_q);
        wr_in_range_c = {1'b0, wrAddrIn} < (ADDR_W + 1)'(FB_WORDS);
        pix_fb_col_c = hPosIn >> SCALE_LOG2;
        pix_col_c    = COL_W'(pix_fb_col_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        row_d       = row_q;
        col_d       = col_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        overrun_d   = overrun_q;
        rd_vld_d    = 1'b0;
        rd_col_d    = rd_col_q;
        cap_vld_d   = rd_vld_q;
        cap_col_d   = rd_col_q;
        pixel_d     = '0;

        if (isDisplayOnIn && (pix_fb_col_c < 16'(FB_WIDTH))) begin
            pixel_d = line_buf_q[pix_col_c];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (trigger_c || pending_q) begin
                    // Issue column 0 right away so it lands one cycle after the trigger.
                    state_d    = ST_PREFETCH;
                    pending_d  = 1'b0;
                    row_d      = row_sel_c;
                    mem_addr_d = first_addr_c;
                    rd_vld_d   = 1'b1;
                    rd_col_d   = '0;
                    col_d      = CNT_W'(1);
                end else if (wrReqIn) begin
                    state_d     = ST_WRITE;
                    mem_addr_d  = wrAddrIn;
                    mem_wdata_d = wrDataIn;
                    mem_we_d    = wr_in_range_c;
                    wr_ack_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (trigger_c) begin
                    pending_d = 1'b1;
                    row_d     = new_row_c;
                end
            end
            ST_PREFETCH: begin
                if (trigger_c) begin
                    overrun_d = 1'b1;
                end
                if (col_q < CNT_W'(FB_WIDTH)) begin
                    mem_addr_d = next_addr_c;
                    rd_vld_d   = 1'b1;
                    rd_col_d   = COL_W'(col_q);
                    col_d      = col_q + CNT_W'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (trigger_c) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            overrun_q   <= 1'b0;
            pixel_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_col_q    <= '0;
            cap_vld_q   <= 1'b0;
            cap_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            overrun_q   <= overrun_d;
            pixel_q     <= pixel_d;
            rd_vld_q    <= rd_vld_d;
            rd_col_q    <= rd_col_d;
            cap_vld_q   <= cap_vld_d;
            cap_col_q   <= cap_col_d;
        end
    end

    // Line buffer fill; contents are not reset.
    always_ff @(posedge clkIn) begin
        if (cap_vld_q) begin
            line_buf_q[cap_col_q] <= memRdataIn;
        end
    end

    assign pixelOut    = pixel_q;
    assign wrAckOut    = wr_ack_q;
    assign memAddrOut  = mem_addr_q;
    assign memWeOut    = mem_we_q;
    assign memWdataOut = mem_wdata_q;
    assign overrunOut  = overrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;

    localparam int unsigned ADDR_W        = 15;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DISPLAY_WIDTH = 800;
    localparam int unsigned H_TOTAL       = 1040;
    localparam int unsigned H_BLANK       = H_TOTAL - DISPLAY_WIDTH;
    localparam int unsigned FB_WIDTH      = 200;

    logic              clkIn = 1'b0;
    logic              rstIn;
    logic [15:0]       hPosIn;
    logic [15:0]       vPosIn;
    logic              isDisplayOnIn;
    logic [DATA_W-1:0] pixelOut;
    logic              wrReqIn;
    logic [ADDR_W-1:0] wrAddrIn;
    logic [DATA_W-1:0] wrDataIn;
    logic              wrAckOut;
    logic [ADDR_W-1:0] memAddrOut;
    logic              memWeOut;
    logic [DATA_W-1:0] memWdataOut;
    logic [DATA_W-1:0] memRdataIn;
    logic              overrunOut;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    vga_fb_arbiter dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .hPosIn       (hPosIn),
        .vPosIn       (vPosIn),
        .isDisplayOnIn(isDisplayOnIn),
        .pixelOut     (pixelOut),
        .wrReqIn      (wrReqIn),
        .wrAddrIn     (wrAddrIn),
        .wrDataIn     (wrDataIn),
        .wrAckOut     (wrAckOut),
        .memAddrOut   (memAddrOut),
        .memWeOut     (memWeOut),
        .memWdataOut  (memWdataOut),
        .memRdataIn   (memRdataIn),
        .overrunOut   (overrunOut)
    );

    always #5 clkIn = ~clkIn;

    // Single-port RAM with one-cycle read latency.
    always @(posedge clkIn) begin
        memRdataIn <= ram[memAddrOut];
        if (memWeOut) ram[memAddrOut] <= memWdataOut;
    end

    function automatic logic [7:0] fb_init(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic set_pos(input int h, input int v, input logic on);
        hPosIn        = 16'(h);
        vPosIn        = 16'(v);
        isDisplayOnIn = on;
    endtask

    // Trigger from line v and run to idle at T+202; optionally check the address sequence.
    task automatic run_prefetch(input int v, input int base, input bit chk_addr);
        set_pos(DISPLAY_WIDTH, v, 1'b0);
        tick();
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        for (int k = 0; k < FB_WIDTH; k++) begin
            if (chk_addr) begin
                check("pf_addr", 32'(memAddrOut), 32'(base + k));
                check("pf_we", 32'(memWeOut), 32'd0);
            end
            if (k < FB_WIDTH - 1) tick();
        end
        tick();
        tick();
    endtask

    task automatic pix_check(input string tag, input int h, input int v, input logic [7:0] exp);
        set_pos(h, v, 1'b1);
        tick();
        check(tag, 32'(pixelOut), 32'(exp));
    endtask

    initial begin
        int n;
        int hs [5];
        hs = '{0, 3, 4, 100, 799};
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = fb_init(a);

        rstIn = 1'b1;
        wrReqIn = 1'b0;
        wrAddrIn = '0;
        wrDataIn = '0;
        set_pos(0, 0, 1'b0);
        tick();
        tick();
        check("rst_pixel", 32'(pixelOut), 32'd0);
        check("rst_ack", 32'(wrAckOut), 32'd0);
        check("rst_addr", 32'(memAddrOut), 32'd0);
        check("rst_we", 32'(memWeOut), 32'd0);
        check("rst_wdata", 32'(memWdataOut), 32'd0);
        check("rst_overrun", 32'(overrunOut), 32'd0);
        rstIn = 1'b0;
        tick();

        // Row 0 from the last line of the frame.
        run_prefetch(665, 0, 1'b1);
        check("idle_hold0", 32'(memAddrOut), 32'd199);
        tick();
        check("idle_hold1", 32'(memAddrOut), 32'd199);
        for (int i = 0; i < 5; i++) pix_check("pix_row0", hs[i], 0, fb_init(hs[i] >> 2));
        set_pos(800, 0, 1'b0);
        tick();
        check("pix_blank", 32'(pixelOut), 32'd0);

        // Reset in the middle of a prefetch.
        set_pos(DISPLAY_WIDTH, 3, 1'b0);
        tick();
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        repeat (49) tick();
        check("mid_pf_addr", 32'(memAddrOut), 32'd249);
        rstIn = 1'b1;
        tick();
        check("mid_rst_addr", 32'(memAddrOut), 32'd0);
        check("mid_rst_we", 32'(memWeOut), 32'd0);
        check("mid_rst_ack", 32'(wrAckOut), 32'd0);
        check("mid_rst_pixel", 32'(pixelOut), 32'd0);
        rstIn = 1'b0;
        repeat (5) tick();
        check("post_rst_idle", 32'(memAddrOut), 32'd0);

        // Row 1, then a repeated line that must not prefetch.
        run_prefetch(3, 200, 1'b1);
        pix_check("pix_row1", 8, 4, fb_init(202));
        set_pos(DISPLAY_WIDTH, 4, 1'b0);
        tick();
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        repeat (5) tick();
        check("no_pf_repeat", 32'(memAddrOut), 32'd399);
        pix_check("pix_reuse", 12, 5, fb_init(203));

        // Plain write, then read it back through a row-0 prefetch.
        set_pos(DISPLAY_WIDTH + 10, 5, 1'b0);
        wrAddrIn = 15'd123;
        wrDataIn = 8'h5A;
        wrReqIn = 1'b1;
        tick();
        check("wr_we", 32'(memWeOut), 32'd1);
        check("wr_addr", 32'(memAddrOut), 32'd123);
        check("wr_wdata", 32'(memWdataOut), 32'h5A);
        check("wr_ack", 32'(wrAckOut), 32'd1);
        wrReqIn = 1'b0;
        tick();
        check("wr_ack_pulse", 32'(wrAckOut), 32'd0);
        check("wr_we_off", 32'(memWeOut), 32'd0);
        run_prefetch(665, 0, 1'b0);
        pix_check("pix_before_wr", 491, 0, fb_init(122));
        for (int h = 492; h <= 495; h++) pix_check("pix_written", h, 0, 8'h5A);

        // Writer and trigger in the same cycle: prefetch wins.
        set_pos(DISPLAY_WIDTH, 665, 1'b0);
        wrAddrIn = 15'd124;
        wrDataIn = 8'hA5;
        wrReqIn = 1'b1;
        tick();
        n = 1;
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        while (!wrAckOut && n < 400) begin
            tick();
            n++;
        end
        check("ack_latency", 32'(n), 32'd203);
        check("late_wr_addr", 32'(memAddrOut), 32'd124);
        check("wait_fits_hblank", 32'(n <= H_BLANK), 32'd1);
        wrReqIn = 1'b0;
        tick();

        // Trigger during WRITE becomes pending; prefetch starts one cycle late.
        wrAddrIn = 15'd125;
        wrDataIn = 8'h11;
        wrReqIn = 1'b1;
        tick();
        check("pend_wr_ack", 32'(wrAckOut), 32'd1);
        wrReqIn = 1'b0;
        set_pos(DISPLAY_WIDTH, 665, 1'b0);
        tick();
        check("pend_hold_addr", 32'(memAddrOut), 32'd125);
        check("pend_hold_we", 32'(memWeOut), 32'd0);
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        tick();
        check("pend_addr0", 32'(memAddrOut), 32'd0);
        tick();
        check("pend_addr1", 32'(memAddrOut), 32'd1);
        repeat (200) tick();
        check("no_overrun", 32'(overrunOut), 32'd0);

        // Forced second trigger during a prefetch.
        set_pos(DISPLAY_WIDTH, 665, 1'b0);
        tick();
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        repeat (99) tick();
        hPosIn = 16'(DISPLAY_WIDTH);
        tick();
        check("overrun_set", 32'(overrunOut), 32'd1);
        check("overrun_addr", 32'(memAddrOut), 32'd100);
        hPosIn = 16'(DISPLAY_WIDTH + 1);
        repeat (110) tick();
        check("overrun_no_restart", 32'(memAddrOut), 32'd199);
        check("overrun_sticky", 32'(overrunOut), 32'd1);

        // Out-of-range write is acknowledged but not performed.
        wrAddrIn = 15'd30000;
        wrDataIn = 8'h77;
        wrReqIn = 1'b1;
        tick();
        check("oob_ack", 32'(wrAckOut), 32'd1);
        check("oob_we", 32'(memWeOut), 32'd0);
        wrReqIn = 1'b0;
        tick();
        check("overrun_sticky2", 32'(overrunOut), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port framebuffer RAM between VGA scanout and a drawing client (CPU/blitter). It watches hPos/vPos from the HV sync generator. During horizontal blanking it prefetches one framebuffer row into an internal line buffer at top priority, and gives all other memory cycles to the writer through a req/ack handshake. Pixels are output from the line buffer, upscaled by 2^SCALE_LOG2 in both axes.

Parameters:
DISPLAY_WIDTH, 800, visible pixels per line
DISPLAY_HEIGHT, 600, visible lines per frame
V_TOTAL, 666, total lines per frame (last line index V_TOTAL-1)
SCALE_LOG2, 2, log2 of the upscale factor; FB pixel = display pixel >> SCALE_LOG2
FB_WIDTH, 200, framebuffer words per row (DISPLAY_WIDTH >> SCALE_LOG2)
FB_HEIGHT, 150, framebuffer rows (DISPLAY_HEIGHT >> SCALE_LOG2)
ADDR_W, 15, RAM address width
DATA_W, 8, pixel/RAM data width

Ports:
clkIn  input  1  pixel clock, shared with the sync generator
rstIn  input  1  synchronous reset, active high
hPosIn  input  16  current column from the sync generator
vPosIn  input  16  current line from the sync generator
isDisplayOnIn  input  1  visible-area flag from the sync generator
pixelOut  output  DATA_W  pixel for the hPos/vPos sampled one cycle earlier; 0 when not visible
wrReqIn  input  1  writer request; held with addr/data until ack
wrAddrIn  input  ADDR_W  writer word address
wrDataIn  input  DATA_W  writer data
wrAckOut  output  1  one-cycle pulse: the write was performed (or dropped)
memAddrOut  output  ADDR_W  RAM address (registered)
memWeOut  output  1  RAM write enable (registered)
memWdataOut  output  DATA_W  RAM write data (registered)
memRdataIn  input  DATA_W  RAM read data, valid 1 cycle after memAddrOut
overrunOut  output  1  sticky: a prefetch trigger arrived while a prefetch was still running

Behaviour:
- Reset: state IDLE, pending=0. pixelOut, wrAckOut, memAddrOut, memWeOut, memWdataOut and overrunOut all 0. Line-buffer contents undefined. Reset mid-prefetch aborts it; the next trigger restarts normally.
- nextV = (vPosIn == V_TOTAL-1) ? 0 : vPosIn+1.
- trigger = (hPosIn == DISPLAY_WIDTH) && (nextV < DISPLAY_HEIGHT) && (nextV[SCALE_LOG2-1:0] == 0). A prefetch runs only on a new FB row; repeated lines reuse the buffer. Latch row = nextV >> SCALE_LOG2 at trigger.
- FSM IDLE / WRITE / PREFETCH / DRAIN:
  - IDLE: trigger or pending -> PREFETCH, clear pending; trigger wins over wrReqIn in the same cycle. Otherwise wrReqIn -> WRITE.
  - WRITE (1 cycle): memWeOut=1, memAddrOut=wrAddrIn, memWdataOut=wrDataIn, wrAckOut=1. If wrAddrIn >= FB_WIDTH*FB_HEIGHT, memWeOut stays 0 but the ack is still given. A trigger in this cycle sets pending. Next state IDLE.
  - PREFETCH: trigger sampled at cycle T. memAddrOut = row*FB_WIDTH + col for col 0..FB_WIDTH-1 on cycles T+1..T+FB_WIDTH, with memWeOut=0. Next state DRAIN.
  - DRAIN: captures the last read, then IDLE. memRdataIn on cycle k+1 is written to lineBuf[col issued at k]. Prefetch occupies FB_WIDTH+2 cycles total.
- Writer is never acked during PREFETCH/DRAIN. Max back-to-back write rate is 1 per 2 cycles. Worst-case wait is FB_WIDTH+3 cycles.
- Trigger while in PREFETCH/DRAIN: ignored and overrunOut <= 1 (sticky until reset).
- pixelOut <= isDisplayOnIn ? lineBuf[hPosIn >> SCALE_LOG2] : 0, a 1-cycle latency. Line buffer reads occur only in the visible area; prefetch writes occur only in blanking, so there is no port conflict.
- memAddrOut holds its last value in IDLE; memWeOut is 0 outside WRITE.
- Arithmetic: row*FB_WIDTH+col is computed in ADDR_W bits. Parameters must satisfy FB_WIDTH+3 <= horizontal blanking length; this is checked by the bench.

Test Plan:
- Reset mid-prefetch (assert rstIn at T+50) -> all outputs 0 next cycle, FSM IDLE, no further memAddrOut sequencing until the next trigger.
- vPosIn=665, hPosIn=800 -> memAddrOut 0..199 on T+1..T+200, idle at T+202. Line 0 pixels then equal RAM[hPos>>2] with 1-cycle latency, and pixelOut=0 at hPos>=800.
- vPosIn=3, hPosIn=800 (nextV=4) -> addresses 200..399. vPosIn=4, hPosIn=800 (nextV=5) -> no prefetch, buffer reused.
- wrReqIn held with addr=123, data=0x5A in IDLE -> next cycle memWeOut=1, memAddrOut=123, memWdataOut=0x5A, wrAckOut=1. A read-back via prefetch of row 0 shows 0x5A at pixel columns 492..495.
- wrReqIn and trigger in the same cycle -> prefetch first, wrAckOut at T+203. Trigger during WRITE -> pending, prefetch starts one cycle late.
- Second trigger forced at T+100 during a prefetch -> overrunOut=1 and stays 1. Write to addr 30000 -> wrAckOut=1, memWeOut=0.
